// File: rtl/rotator_cmd_sequencer_pkg.sv
// ============================================================================
// rotator_cmd_sequencer_pkg : op encodings and sequencer state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package rotator_cmd_sequencer_pkg;

   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_ROR  = 2'b01;
   localparam logic [1:0] OP_ROL  = 2'b10;
   localparam logic [1:0] OP_ASR  = 2'b11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      SHIFT   = 3'd2,
      CAPTURE = 3'd3,
      RESULT  = 3'd4
   } state_e;

endpackage

`default_nettype wire

// File: rtl/rotator_cmd_sequencer_if.sv
// ============================================================================
// rotator_cmd_sequencer_if : command and result valid/ready handshakes
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rotator_cmd_sequencer_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [WIDTH-1:0] cmd_data;
   logic [CNT_W-1:0] cmd_count;
   logic             res_valid;
   logic             res_ready;
   logic [WIDTH-1:0] res_data;

   modport master (
      output cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
      input  cmd_ready, res_valid, res_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data, cmd_count, res_ready,
      output cmd_ready, res_valid, res_data
   );
endinterface

`default_nettype wire

// File: rtl/rotator_step_counter.sv
// ============================================================================
// rotator_step_counter : loadable down-counter, flags terminal count of one
// Revision: 1.0
// ============================================================================
`default_nettype none

module rotator_step_counter #(
   parameter int CNT_W = 4
) (
   input  wire logic             clock,
   input  wire logic             Reset_b,
   input  wire logic             i_load,
   input  wire logic [CNT_W-1:0] i_load_value,
   input  wire logic             i_dec,
   output logic                  o_tc
);
   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clock or negedge Reset_b) begin
      if (!Reset_b) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_tc = (r_count == CNT_W'(1));
endmodule

`default_nettype wire

// File: rtl/rotator_cmd_sequencer.sv
// ============================================================================
// rotator_cmd_sequencer : sequences load/shift/capture on the rotate register
// Revision: 1.0
// ============================================================================
`default_nettype none

module rotator_cmd_sequencer
   import rotator_cmd_sequencer_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  wire logic             clock,
   input  wire logic             Reset_b,
   rotator_cmd_sequencer_if.slave bus,
   output logic                  ParallelLoadn,
   output logic                  RotateRight,
   output logic                  ASRight,
   output logic [WIDTH-1:0]      Data_IN,
   input  wire logic [WIDTH-1:0] Q_in
);
   localparam logic [2:0] c_ST_IDLE    = IDLE;
   localparam logic [2:0] c_ST_LOAD    = LOAD;
   localparam logic [2:0] c_ST_SHIFT   = SHIFT;
   localparam logic [2:0] c_ST_CAPTURE = CAPTURE;
   localparam logic [2:0] c_ST_RESULT  = RESULT;

   logic [2:0]       r_state;
   logic [1:0]       r_op;
   logic [WIDTH-1:0] r_data;
   logic             r_zero;
   logic [WIDTH-1:0] r_res_data;
   logic [WIDTH-1:0] r_park;

   logic             w_cmd_ready;
   logic             w_accept;
   logic [CNT_W-1:0] w_load_cnt;
   logic             w_tc;
   logic             w_shifting;

   assign w_cmd_ready = Reset_b && (r_state == c_ST_IDLE);
   assign w_accept    = bus.cmd_valid && w_cmd_ready;
   assign w_load_cnt  = (bus.cmd_op == OP_LOAD) ? '0 : bus.cmd_count;

   rotator_step_counter #(.CNT_W(CNT_W)) u_step_counter (
      .clock        (clock),
      .Reset_b      (Reset_b),
      .i_load       (w_accept),
      .i_load_value (w_load_cnt),
      .i_dec        (r_state == c_ST_SHIFT),
      .o_tc         (w_tc)
   );

   always_ff @(posedge clock or negedge Reset_b) begin
      if (!Reset_b) begin
         r_state    <= c_ST_IDLE;
         r_op       <= OP_LOAD;
         r_data     <= '0;
         r_zero     <= 1'b1;
         r_res_data <= '0;
         r_park     <= '0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_accept) begin
                  r_op    <= bus.cmd_op;
                  r_data  <= bus.cmd_data;
                  r_zero  <= (w_load_cnt == '0);
                  r_state <= c_ST_LOAD;
               end
            end
            c_ST_LOAD:    r_state <= r_zero ? c_ST_CAPTURE : c_ST_SHIFT;
            c_ST_SHIFT:   if (w_tc) r_state <= c_ST_CAPTURE;
            c_ST_CAPTURE: begin
               r_res_data <= Q_in;
               r_park     <= Q_in;
               r_state    <= c_ST_RESULT;
            end
            c_ST_RESULT:  if (bus.res_ready) r_state <= c_ST_IDLE;
            default:      r_state <= c_ST_IDLE;
         endcase
      end
   end

   // Capture keeps the previous cycle's controls; its own edge shifts again but Q is already sampled.
   assign w_shifting = (r_state == c_ST_SHIFT) || ((r_state == c_ST_CAPTURE) && !r_zero);

   always_comb begin
      ParallelLoadn = 1'b0;
      RotateRight   = 1'b0;
      ASRight       = 1'b0;
      Data_IN       = r_park;
      if ((r_state == c_ST_LOAD) || ((r_state == c_ST_CAPTURE) && r_zero)) begin
         Data_IN = r_data;
      end
      if (w_shifting) begin
         ParallelLoadn = 1'b1;
         RotateRight   = (r_op != OP_ROL);
         ASRight       = (r_op == OP_ASR);
      end
   end

   assign bus.cmd_ready = w_cmd_ready;
   assign bus.res_valid = (r_state == c_ST_RESULT);
   assign bus.res_data  = r_res_data;
endmodule

`default_nettype wire

// File: tb/tb_rotator_cmd_sequencer.sv
// ============================================================================
// tb_rotator_cmd_sequencer : sequencer driving a behavioural rotate register
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rotator_cmd_sequencer;
   import rotator_cmd_sequencer_pkg::*;

   typedef struct {
      logic [7:0] data;
      int         rv_cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       Reset_b;
   logic       ParallelLoadn;
   logic       RotateRight;
   logic       ASRight;
   logic [7:0] Data_IN;
   logic [7:0] r_q;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         watch_pl = 1'b0;
   bit         watch_rol = 1'b0;
   exp_t       sb[$];

   rotator_cmd_sequencer_if #(.WIDTH(8), .CNT_W(4)) bus ();

   rotator_cmd_sequencer #(.WIDTH(8), .CNT_W(4)) dut (
      .clock         (clock),
      .Reset_b       (Reset_b),
      .bus           (bus),
      .ParallelLoadn (ParallelLoadn),
      .RotateRight   (RotateRight),
      .ASRight       (ASRight),
      .Data_IN       (Data_IN),
      .Q_in          (r_q)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // The parallel-load / rotate / arithmetic-shift register being sequenced.
   always @(posedge clock or negedge Reset_b) begin
      if (!Reset_b)            r_q <= 8'h00;
      else if (!ParallelLoadn) r_q <= Data_IN;
      else if (ASRight)        r_q <= {r_q[7], r_q[7:1]};
      else if (RotateRight)    r_q <= {r_q[0], r_q[7:1]};
      else                     r_q <= {r_q[6:0], r_q[7]};
   end

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic monitor();
      bit         prev_rv = 1'b0;
      logic [7:0] held = 8'h00;
      exp_t       e;
      forever begin
         @(negedge clock);
         #2;
         if (Reset_b) begin
            if (bus.res_valid && !prev_rv) begin
               if (sb.size() == 0) begin
                  chk(1'b0, "unexpected_result", {24'd0, bus.res_data}, 32'd0);
               end else begin
                  chk(cyc == sb[0].rv_cyc, "result_latency_cycle", cyc, sb[0].rv_cyc);
               end
               held = bus.res_data;
            end else if (bus.res_valid) begin
               chk(bus.res_data == held, "res_data_stable", {24'd0, bus.res_data}, {24'd0, held});
            end
            if (bus.res_valid && bus.res_ready && sb.size() > 0) begin
               e = sb.pop_front();
               chk(bus.res_data == e.data, "res_data", {24'd0, bus.res_data}, {24'd0, e.data});
            end
            if (watch_pl) chk(ParallelLoadn == 1'b0, "load_only_ParallelLoadn", ParallelLoadn, 0);
            if (watch_rol && ParallelLoadn) chk(RotateRight == 1'b0, "rol_RotateRight", RotateRight, 0);
         end
         prev_rv = Reset_b ? bus.res_valid : 1'b0;
      end
   endtask

   // Called right after a falling edge; returns one falling edge after the accept edge.
   task automatic send_cmd(input logic [1:0] op, input logic [7:0] d, input logic [3:0] n,
                           input logic [7:0] expv, input bit push, output int acc);
      int   waited = 0;
      int   effn;
      exp_t e;
      acc = -1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      bus.cmd_count = n;
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && waited < 200) begin
         @(negedge clock);
         waited++;
      end
      if (!bus.cmd_ready) begin
         chk(1'b0, "cmd_accept_timeout", 0, 1);
         bus.cmd_valid = 1'b0;
      end else begin
         effn = (op == OP_LOAD) ? 0 : int'(n);
         acc  = cyc + 1;
         if (push) begin
            e.data   = expv;
            e.rv_cyc = acc + effn + 2;
            sb.push_back(e);
         end
         @(negedge clock);
         bus.cmd_valid = 1'b0;
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while ((sb.size() != 0 || bus.res_valid) && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (sb.size() != 0 || bus.res_valid) chk(1'b0, "result_timeout", sb.size(), 0);
      @(negedge clock);
   endtask

   initial begin
      int acc;
      int hs;
      int n;
      bit seen;
      Reset_b       = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 8'h00;
      bus.cmd_count = 4'd0;
      bus.res_ready = 1'b1;
      fork
         monitor();
      join_none
      #1;
      chk(bus.cmd_ready == 1'b0, "reset_cmd_ready", bus.cmd_ready, 0);
      chk(bus.res_valid == 1'b0, "reset_res_valid", bus.res_valid, 0);
      chk(bus.res_data == 8'h00, "reset_res_data", bus.res_data, 0);
      chk(ParallelLoadn == 1'b0, "reset_ParallelLoadn", ParallelLoadn, 0);
      chk(Data_IN == 8'h00, "reset_Data_IN", Data_IN, 0);
      chk({RotateRight, ASRight} == 2'b00, "reset_dir", {RotateRight, ASRight}, 0);
      repeat (2) @(negedge clock);
      Reset_b = 1'b1;
      @(negedge clock);
      chk(bus.cmd_ready == 1'b1, "idle_cmd_ready", bus.cmd_ready, 1);

      // Load-only: count ignored, register never released from load.
      watch_pl = 1'b1;
      send_cmd(OP_LOAD, 8'hA5, 4'd5, 8'hA5, 1'b1, acc);
      wait_done();
      watch_pl = 1'b0;

      send_cmd(OP_ROR, 8'h81, 4'd1, 8'hC0, 1'b1, acc);
      wait_done();
      send_cmd(OP_ROR, 8'h81, 4'd8, 8'h81, 1'b1, acc);
      wait_done();

      watch_rol = 1'b1;
      send_cmd(OP_ROL, 8'h81, 4'd3, 8'h0C, 1'b1, acc);
      wait_done();
      watch_rol = 1'b0;

      send_cmd(OP_ASR, 8'h90, 4'd2, 8'hE4, 1'b1, acc);
      wait_done();
      send_cmd(OP_ASR, 8'h90, 4'd15, 8'hFF, 1'b1, acc);
      wait_done();

      // Back-pressure on the result while a second command is waiting.
      bus.res_ready = 1'b0;
      send_cmd(OP_ROR, 8'h81, 4'd1, 8'hC0, 1'b1, acc);
      bus.cmd_op    = OP_LOAD;
      bus.cmd_data  = 8'h3C;
      bus.cmd_count = 4'd0;
      bus.cmd_valid = 1'b1;
      n = 0;
      while (!bus.res_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      chk(bus.res_valid == 1'b1, "stall_res_valid_seen", bus.res_valid, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         #1;
         chk(bus.cmd_ready == 1'b0, "stall_cmd_ready", bus.cmd_ready, 0);
         chk(r_q == 8'hC0, "stall_register_q", r_q, 8'hC0);
         chk(bus.res_valid == 1'b1, "stall_res_valid", bus.res_valid, 1);
      end
      bus.res_ready = 1'b1;
      hs = cyc + 1;
      send_cmd(OP_LOAD, 8'h3C, 4'd0, 8'h3C, 1'b1, acc);
      chk(acc == hs + 1, "second_cmd_accept_edge", acc, hs + 1);
      wait_done();

      // Reset in the middle of a long shift aborts the command.
      send_cmd(OP_ROR, 8'h5A, 4'd10, 8'h00, 1'b0, acc);
      repeat (3) @(negedge clock);
      chk(ParallelLoadn == 1'b1, "abort_in_shift", ParallelLoadn, 1);
      #1;
      Reset_b = 1'b0;
      #1;
      chk(bus.res_valid == 1'b0, "abort_res_valid", bus.res_valid, 0);
      chk(ParallelLoadn == 1'b0, "abort_ParallelLoadn", ParallelLoadn, 0);
      chk(Data_IN == 8'h00, "abort_Data_IN", Data_IN, 0);
      chk(bus.cmd_ready == 1'b0, "abort_cmd_ready", bus.cmd_ready, 0);
      chk({RotateRight, ASRight} == 2'b00, "abort_dir", {RotateRight, ASRight}, 0);
      @(negedge clock);
      Reset_b = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         if (bus.res_valid) seen = 1'b1;
      end
      chk(seen == 1'b0, "abort_no_result", seen, 0);

      send_cmd(OP_LOAD, 8'h42, 4'd0, 8'h42, 1'b1, acc);
      wait_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

`default_nettype wire
